// File: rtl/uoram_req_arbiter.sv
// uoram_req_arbiter: round-robin arbiter sharing one UORAM frontend among NumReq requesters,
// holding each grant for one full block. Define UORAM_ARB_PRIO0_EN to give requester 0 strict priority.
module uoram_req_arbiter #(
   parameter int NumReq = 2,
   parameter int BECMDWidth = 2,
   parameter int ORAMU = 32,
   parameter int FEDWidth = 64,
   parameter int BlkSize_FEDChunks = 8,
   parameter logic [BECMDWidth-1:0] CmdUpdate = 2'd0,
   parameter logic [BECMDWidth-1:0] CmdAppend = 2'd1,
   parameter logic [BECMDWidth-1:0] CmdRead = 2'd2,
   parameter logic [BECMDWidth-1:0] CmdReadRmv = 2'd3
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic [NumReq-1:0]              ReqCmdValid,
   output logic [NumReq-1:0]              ReqCmdReady,
   input  logic [NumReq*BECMDWidth-1:0]   ReqCmd,
   input  logic [NumReq*ORAMU-1:0]        ReqAddr,
   input  logic [NumReq-1:0]              ReqDataValid,
   output logic [NumReq-1:0]              ReqDataReady,
   input  logic [NumReq*FEDWidth-1:0]     ReqData,
   output logic [NumReq-1:0]              RespValid,
   input  logic [NumReq-1:0]              RespReady,
   output logic [FEDWidth-1:0]            RespData,
   output logic                           CmdInValid,
   input  logic                           CmdInReady,
   output logic [BECMDWidth-1:0]          CmdIn,
   output logic [ORAMU-1:0]               ProgAddrIn,
   output logic                           DataInValid,
   input  logic                           DataInReady,
   output logic [FEDWidth-1:0]            DataIn,
   input  logic                           ReturnDataValid,
   output logic                           ReturnDataReady,
   input  logic [FEDWidth-1:0]            ReturnData,
   output logic [$clog2(NumReq)-1:0]      Grant,
   output logic                           Busy
);
   localparam int GW = $clog2(NumReq);
   localparam int CW = $clog2(BlkSize_FEDChunks);

   typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RDATA} state_t;

   state_t                r_state, w_next;
   logic [GW-1:0]         r_ptr, r_grant, w_pick, w_ptr_nxt;
   logic [CW-1:0]         r_cnt;
   logic [NumReq-1:0]     w_onehot;
   logic [BECMDWidth-1:0] w_cmd;
   logic [ORAMU-1:0]      w_addr;
   logic [FEDWidth-1:0]   w_wdata;
   logic                  w_found, w_cvalid, w_dvalid, w_rready;
   logic                  w_cmd_hs, w_dat_hs, w_ret_hs, w_last, w_is_rd;
   int                    w_dist, w_best;

   // Closest valid requester at or above the pointer, measured with wrap-around distance.
   always_comb begin
      w_found = 1'b0;
      w_pick = '0;
      w_best = NumReq;
      w_dist = 0;
      for (int i = 0; i < NumReq; i++) begin
         w_dist = (i + NumReq - int'(r_ptr)) % NumReq;
         if (ReqCmdValid[i] && w_dist < w_best) begin
            w_best = w_dist;
            w_pick = GW'(i);
            w_found = 1'b1;
         end
      end
`ifdef UORAM_ARB_PRIO0_EN
      if (ReqCmdValid[0]) w_pick = '0;
`endif
   end

   always_comb begin
      w_cmd = '0;
      w_addr = '0;
      w_wdata = '0;
      w_cvalid = 1'b0;
      w_dvalid = 1'b0;
      w_rready = 1'b0;
      for (int i = 0; i < NumReq; i++) begin
         if (r_grant == GW'(i)) begin
            w_cmd = ReqCmd[i*BECMDWidth +: BECMDWidth];
            w_addr = ReqAddr[i*ORAMU +: ORAMU];
            w_wdata = ReqData[i*FEDWidth +: FEDWidth];
            w_cvalid = ReqCmdValid[i];
            w_dvalid = ReqDataValid[i];
            w_rready = RespReady[i];
         end
      end
   end

   assign w_onehot  = NumReq'(1) << r_grant;
   assign w_cmd_hs  = r_state == ISSUE && w_cvalid && CmdInReady;
   assign w_dat_hs  = r_state == WDATA && w_dvalid && DataInReady;
   assign w_ret_hs  = r_state == RDATA && ReturnDataValid && w_rready;
   assign w_last    = &r_cnt;
   assign w_is_rd   = w_cmd == CmdRead || w_cmd == CmdReadRmv;
   assign w_ptr_nxt = (r_grant == GW'(NumReq-1)) ? '0 : r_grant + 1'b1;

   assign CmdInValid      = r_state == ISSUE && w_cvalid;
   assign ReqCmdReady     = (r_state == ISSUE && CmdInReady) ? w_onehot : '0;
   assign DataInValid     = r_state == WDATA && w_dvalid;
   assign ReqDataReady    = (r_state == WDATA && DataInReady) ? w_onehot : '0;
   assign RespValid       = (r_state == RDATA && ReturnDataValid) ? w_onehot : '0;
   assign ReturnDataReady = r_state == RDATA && w_rready;
   assign CmdIn           = w_cmd;
   assign ProgAddrIn      = w_addr;
   assign DataIn          = w_wdata;
   assign RespData        = ReturnData;
   assign Grant           = r_grant;
   assign Busy            = r_state != IDLE;

   always_comb begin
      w_next = r_state;
      w_next = r_state == IDLE  ? (w_found ? ISSUE : IDLE) :
               r_state == ISSUE ? (w_cmd_hs ? (w_is_rd ? RDATA : WDATA) : ISSUE) :
               ((w_dat_hs || w_ret_hs) && w_last) ? IDLE : r_state;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
         r_ptr <= '0;
         r_cnt <= '0;
         r_grant <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_found) r_grant <= w_pick;
         if (w_cmd_hs) begin
            r_cnt <= '0;
`ifdef UORAM_ARB_PRIO0_EN
            if (r_grant != '0) r_ptr <= w_ptr_nxt;
`else
            r_ptr <= w_ptr_nxt;
`endif
         end
         if (w_dat_hs || w_ret_hs) r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_uoram_req_arbiter.sv
// tb_uoram_req_arbiter: directed and randomized transactions against a rotation/priority reference model.
module tb_uoram_req_arbiter;
   localparam int NR = 2, CW = 2, AW = 32, DW = 64, BS = 8;

   logic             Clock = 1'b0;
   logic             Reset;
   logic [NR-1:0]    ReqCmdValid, ReqCmdReady, ReqDataValid, ReqDataReady, RespValid, RespReady;
   logic [NR*CW-1:0] ReqCmd;
   logic [NR*AW-1:0] ReqAddr;
   logic [NR*DW-1:0] ReqData;
   logic [DW-1:0]    RespData, DataIn, ReturnData;
   logic             CmdInValid, CmdInReady, DataInValid, DataInReady;
   logic             ReturnDataValid, ReturnDataReady, Busy;
   logic [CW-1:0]    CmdIn;
   logic [AW-1:0]    ProgAddrIn;
   logic [0:0]       Grant;

   int            checks = 0, failures = 0, m_ptr = 0;
   logic [DW-1:0] wdat [NR][BS];
   logic [CW-1:0] m_cmd [NR];
   logic [AW-1:0] m_addr [NR];

   uoram_req_arbiter dut (
      .Clock(Clock), .Reset(Reset),
      .ReqCmdValid(ReqCmdValid), .ReqCmdReady(ReqCmdReady), .ReqCmd(ReqCmd), .ReqAddr(ReqAddr),
      .ReqDataValid(ReqDataValid), .ReqDataReady(ReqDataReady), .ReqData(ReqData),
      .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
      .CmdInValid(CmdInValid), .CmdInReady(CmdInReady), .CmdIn(CmdIn), .ProgAddrIn(ProgAddrIn),
      .DataInValid(DataInValid), .DataInReady(DataInReady), .DataIn(DataIn),
      .ReturnDataValid(ReturnDataValid), .ReturnDataReady(ReturnDataReady), .ReturnData(ReturnData),
      .Grant(Grant), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Grant chosen by the arbitration rules: rotate from the pointer, requester 0 first when prioritised.
   function automatic int model_grant(input logic [NR-1:0] v);
      logic [2*NR-1:0] vv;
`ifdef UORAM_ARB_PRIO0_EN
      if (v[0]) return 0;
`endif
      vv = {v, v} >> m_ptr;
      for (int k = 0; k < NR; k++) if (vv[k]) return (m_ptr + k) % NR;
      return -1;
   endfunction

   task automatic clear_in();
      ReqCmdValid = '0; ReqDataValid = '0; RespReady = '0; ReqData = '0;
      CmdInReady = 1'b0; DataInReady = 1'b0; ReturnDataValid = 1'b0; ReturnData = '0;
   endtask

   task automatic setup(input int r, input logic [CW-1:0] cmd, input logic [AW-1:0] addr, input bit seq);
      m_cmd[r] = cmd;
      m_addr[r] = addr;
      ReqCmd[r*CW +: CW] = cmd;
      ReqAddr[r*AW +: AW] = addr;
      for (int k = 0; k < BS; k++) wdat[r][k] = seq ? 64'(k + 1) : {$urandom, $urandom};
   endtask

   // Inputs are driven hot so the outputs can only be quiet because of reset.
   task automatic reset_chk(input string tag);
      Reset = 1'b1;
      ReqCmdValid = '1; ReqDataValid = '1; RespReady = '1;
      CmdInReady = 1'b1; DataInReady = 1'b1; ReturnDataValid = 1'b1;
      #1;
      chk({tag, "_outs"}, 64'({CmdInValid, ReqCmdReady, DataInValid, ReqDataReady, RespValid, ReturnDataReady, Busy}), 64'd0);
      chk({tag, "_grant"}, 64'(Grant), 64'd0);
      m_ptr = 0;
      clear_in();
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      #1 chk({tag, "_busy_after"}, 64'(Busy), 64'd0);
   endtask

   task automatic txn(input string tag, input logic [NR-1:0] vm, input bit keep, input int stall,
                      input int bp, input int abort);
      int g, n, cyc;
      bit rd, r, v;
      logic [NR-1:0] oh;
      logic [DW-1:0] rdat;
      ReqCmdValid = vm;
      g = model_grant(vm);
      oh = NR'(1) << g;
      #1 chk({tag, "_idle"}, 64'(Busy), 64'd0);
      @(negedge Clock); #1;
      chk({tag, "_grant"}, 64'(Grant), 64'(g));
      for (int s = 0; s < stall; s++) begin
         chk({tag, "_stall"}, 64'({Busy, CmdInValid, ReqCmdReady, Grant}), 64'({2'b11, 2'b00, 1'(g)}));
         @(negedge Clock); #1;
      end
      CmdInReady = 1'b1;
      #1 chk({tag, "_cmd"}, 64'({CmdInValid, ReqCmdReady, CmdIn, ProgAddrIn}), 64'({1'b1, oh, m_cmd[g], m_addr[g]}));
      @(posedge Clock);
`ifdef UORAM_ARB_PRIO0_EN
      if (g != 0) m_ptr = (g + 1) % NR;
`else
      m_ptr = (g + 1) % NR;
`endif
      @(negedge Clock);
      CmdInReady = 1'b0;
      if (!keep) ReqCmdValid = ReqCmdValid & ~oh;
      rd = m_cmd[g] == 2'd2 || m_cmd[g] == 2'd3;
      n = 0;
      cyc = 0;
      while (n < BS && cyc < 200) begin
         if (abort > 0 && n == abort) begin
            reset_chk({tag, "_rst"});
            return;
         end
         r = bp == 0 ? 1'b1 : bp == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         if (!rd) begin
            ReqDataValid = oh;
            ReqData = {$urandom, $urandom, $urandom, $urandom};
            ReqData[g*DW +: DW] = wdat[g][n];
            DataInReady = r;
            #1;
            chk({tag, "_wr_ctl"}, 64'({DataInValid, ReqDataReady, RespValid, ReturnDataReady, Busy}),
                64'({1'b1, r ? oh : 2'b00, 2'b00, 1'b0, 1'b1}));
            chk({tag, "_wr_data"}, DataIn, wdat[g][n]);
         end else begin
            v = bp == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdat = {$urandom, $urandom};
            ReturnDataValid = v;
            ReturnData = rdat;
            RespReady = (NR'($urandom) & ~oh) | (r ? oh : '0);
            #1;
            chk({tag, "_rd_ctl"}, 64'({RespValid, ReturnDataReady, DataInValid, ReqDataReady, Busy}),
                64'({v ? oh : 2'b00, r, 1'b0, 2'b00, 1'b1}));
            chk({tag, "_rd_data"}, RespData, rdat);
            r = r & v;
         end
         @(negedge Clock);
         if (r) n++;
         cyc++;
      end
      chk({tag, "_chunks"}, 64'(n), 64'(BS));
      ReqDataValid = '0; DataInReady = 1'b0; ReturnDataValid = 1'b0; RespReady = '0;
      #1 chk({tag, "_done"}, 64'({Busy, RespValid, ReqDataReady, DataInValid}), 64'd0);
   endtask

   initial begin
      Reset = 1'b1;
      clear_in();
      ReqCmd = '0;
      ReqAddr = '0;
      repeat (2) @(negedge Clock);
      reset_chk("rst0");

      setup(1, 2'd0, 32'h40, 1'b1);
      txn("wr_single", 2'b10, 1'b0, 0, 0, 0);
      setup(0, 2'd1, $urandom, 1'b0);
      txn("wr_bp", 2'b01, 1'b0, 0, 1, 0);
      setup(1, 2'd2, $urandom, 1'b0);
      txn("rd_bp", 2'b10, 1'b0, 0, 1, 0);

      @(negedge Clock);
      reset_chk("rst1");
      setup(0, 2'd2, $urandom, 1'b0);
      setup(1, 2'd3, $urandom, 1'b0);
      for (int t = 0; t < 4; t++) txn("contend", 2'b11, 1'b1, 0, 2, 0);
      ReqCmdValid = '0;

      setup(0, 2'd0, $urandom, 1'b0);
      setup(1, 2'd1, $urandom, 1'b0);
      txn("stall", 2'b11, 1'b0, 20, 0, 0);
      ReqCmdValid = '0;

      setup(0, 2'd0, $urandom, 1'b0);
      txn("abort", 2'b01, 1'b0, 0, 0, 3);
      setup(0, 2'd2, $urandom, 1'b0);
      setup(1, 2'd2, $urandom, 1'b0);
      txn("post_rst", 2'b11, 1'b0, 0, 0, 0);
      ReqCmdValid = '0;

      for (int t = 0; t < 6; t++) begin
         setup(0, 2'($urandom_range(0, 3)), $urandom, 1'b0);
         setup(1, 2'($urandom_range(0, 3)), $urandom, 1'b0);
         txn("random", 2'($urandom_range(1, 3)), 1'b0, $urandom_range(0, 2), 2, 0);
         ReqCmdValid = '0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
